// File: rtl/region_reader_pkg.sv
// region_reader_pkg
//   Shared constants and types for the region reader.
//   - SCREEN_W / SCREEN_H : visible framebuffer extent in pixels
//   - DEF_SIZE            : default side length of the scanned square
//   - DEF_BG_COLOR        : default colour treated as empty background
//   - state_t             : scan FSM state encoding
//   - pix_t               : address + valid travelling with an outstanding read
//   - on_screen()         : bounds test on un-truncated coordinates
package region_reader_pkg;

    localparam int SCREEN_W = 160;
    localparam int SCREEN_H = 120;

    localparam int          DEF_SIZE     = 16;
    localparam logic [2:0]  DEF_BG_COLOR = 3'b000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SCAN  = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // One outstanding framebuffer read: the address that was issued and
    // whether a read strobe actually went out for it.
    typedef struct packed {
        logic       vld;
        logic [7:0] x;
        logic [6:0] y;
    } pix_t;

    // Coordinates are passed un-truncated (origin + offset) so that an
    // offset which wraps past the 8/7-bit address range still reads as
    // off-screen rather than aliasing back onto the visible area.
    function automatic logic on_screen(input logic [9:0] ux, input logic [9:0] uy);
        return (ux < 10'(SCREEN_W)) && (uy < 10'(SCREEN_H));
    endfunction

endpackage

// File: rtl/region_counter.sv
// region_counter
//   Raster offset generator for a SIZE x SIZE region: dx runs 0..SIZE-1 in
//   the inner loop, dy 0..SIZE-1 in the outer loop.
//   Ports:
//     clock, resetn    : system clock, asynchronous active-low reset
//     clr              : restart at offset (0,0)
//     en               : advance to the next offset
//     dx_next, dy_next : offset that follows the current one
//     last             : current offset is (SIZE-1, SIZE-1)
//   The current offset is kept internal; the reader only needs the next one
//   because its address outputs are registered one step ahead.
module region_counter
    import region_reader_pkg::*;
#(
    parameter int SIZE = DEF_SIZE,
    parameter int CW   = (SIZE > 1) ? $clog2(SIZE) : 1
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          clr,
    input  logic          en,
    output logic [CW-1:0] dx_next,
    output logic [CW-1:0] dy_next,
    output logic          last
);

    localparam logic [CW-1:0] MAX = CW'(SIZE - 1);

    logic [CW-1:0] dx;
    logic [CW-1:0] dy;
    logic          row_end;

    always_comb begin
        row_end = (dx == MAX);
        dx_next = row_end ? '0 : dx + CW'(1);
        dy_next = dy;
        if (row_end) begin
            dy_next = (dy == MAX) ? '0 : dy + CW'(1);
        end
        last = row_end && (dy == MAX);
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            dx <= '0;
            dy <= '0;
        end else if (clr) begin
            dx <= '0;
            dy <= '0;
        end else if (en) begin
            dx <= dx_next;
            dy <= dy_next;
        end
    end

endmodule

// File: rtl/region_reader.sv
// region_reader
//   Scans a SIZE x SIZE framebuffer region in raster order, one pixel per
//   cycle, and reports whether any non-background pixel was found, how many,
//   and where the first one was.
//   Ports:
//     clock, resetn          : system clock, asynchronous active-low reset
//     start, x0, y0          : scan request and region top-left corner
//     rd_x, rd_y, rd_en      : framebuffer read address and strobe
//     rd_color               : read data, returned one cycle after rd_en
//     busy, done             : scan in progress / one-cycle completion pulse
//     hit, hit_count         : any hit / number of hits (0..SIZE*SIZE)
//     first_hit_x/_y         : address of the first hit in raster order
//   Timing, counted from the accept cycle (0): addresses go out in cycles
//   1..SIZE*SIZE, data returns in 2..SIZE*SIZE+1 (the DRAIN cycle covers the
//   final return), and done pulses one cycle after that.
module region_reader
    import region_reader_pkg::*;
#(
    parameter int         SIZE     = DEF_SIZE,
    parameter logic [2:0] BG_COLOR = DEF_BG_COLOR
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       start,
    input  logic [7:0] x0,
    input  logic [6:0] y0,
    output logic [7:0] rd_x,
    output logic [6:0] rd_y,
    output logic       rd_en,
    input  logic [2:0] rd_color,
    output logic       busy,
    output logic       done,
    output logic       hit,
    output logic [8:0] hit_count,
    output logic [7:0] first_hit_x,
    output logic [6:0] first_hit_y
);

    localparam int CW = (SIZE > 1) ? $clog2(SIZE) : 1;

    state_t        state;
    logic [7:0]    org_x;
    logic [6:0]    org_y;
    logic [CW-1:0] dx_next;
    logic [CW-1:0] dy_next;
    logic          last;
    logic          accept;
    pix_t          pipe;

    logic [7:0]    base_x;
    logic [6:0]    base_y;
    logic [CW-1:0] off_dx;
    logic [CW-1:0] off_dy;
    logic [9:0]    ux;
    logic [9:0]    uy;

    assign accept = (state == ST_IDLE) && start;

    region_counter #(
        .SIZE (SIZE),
        .CW   (CW)
    ) u_cnt (
        .clock   (clock),
        .resetn  (resetn),
        .clr     (accept),
        .en      (state == ST_SCAN),
        .dx_next (dx_next),
        .dy_next (dy_next),
        .last    (last)
    );

    // Address of the next read. In IDLE the first address is formed straight
    // from the live x0/y0 so it can be registered on the accept edge; after
    // that only the latched origin is used, so x0/y0 may change freely.
    always_comb begin
        base_x = org_x;
        base_y = org_y;
        off_dx = dx_next;
        off_dy = dy_next;
        if (state == ST_IDLE) begin
            base_x = x0;
            base_y = y0;
            off_dx = '0;
            off_dy = '0;
        end
        ux = {2'b00, base_x} + 10'(off_dx);
        uy = {3'b000, base_y} + 10'(off_dy);
    end

    // Control FSM; all control outputs are registered here.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state <= ST_IDLE;
            org_x <= '0;
            org_y <= '0;
            rd_x  <= '0;
            rd_y  <= '0;
            rd_en <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        org_x <= x0;
                        org_y <= y0;
                        rd_x  <= ux[7:0];
                        rd_y  <= uy[6:0];
                        rd_en <= on_screen(ux, uy);
                        busy  <= 1'b1;
                        state <= ST_SCAN;
                    end
                end
                ST_SCAN: begin
                    if (last) begin
                        rd_en <= 1'b0;
                        state <= ST_DRAIN;
                    end else begin
                        rd_x  <= ux[7:0];
                        rd_y  <= uy[6:0];
                        rd_en <= on_screen(ux, uy);
                    end
                end
                ST_DRAIN: begin
                    // Final read data is consumed on this edge.
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    state <= ST_DONE;
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Read-return path: the issued address rides one stage behind rd_en so
    // it lines up with rd_color. Off-screen offsets never set vld, so
    // whatever rd_color carries for them is ignored.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            pipe        <= '0;
            hit         <= 1'b0;
            hit_count   <= '0;
            first_hit_x <= '0;
            first_hit_y <= '0;
        end else begin
            pipe <= '{vld: rd_en, x: rd_x, y: rd_y};
            if (accept) begin
                hit         <= 1'b0;
                hit_count   <= '0;
                first_hit_x <= '0;
                first_hit_y <= '0;
            end else if (pipe.vld && (rd_color != BG_COLOR)) begin
                // 9 bits hold up to 256 hits, so no saturation is needed.
                hit_count <= hit_count + 9'd1;
                if (!hit) begin
                    hit         <= 1'b1;
                    first_hit_x <= pipe.x;
                    first_hit_y <= pipe.y;
                end
            end
        end
    end

endmodule

// File: tb/tb_region_reader.sv
// tb_region_reader
//   Directed bench for region_reader. A framebuffer model answers reads one
//   cycle after rd_en. Each accepted scan pushes its full expected address
//   sequence and final result into queues; a negedge monitor pops and
//   compares them as the DUT produces them, and also checks busy/done every
//   cycle.
module tb_region_reader;

    typedef struct {
        int         cyc;
        logic       en;
        logic [7:0] x;
        logic [6:0] y;
    } addr_t;

    typedef struct {
        int         acc;
        int         dcyc;
        logic       hit;
        logic [8:0] cnt;
        logic [7:0] fx;
        logic [6:0] fy;
    } res_t;

    logic       clock = 1'b0;
    logic       resetn = 1'b0;
    logic       start = 1'b0;
    logic [7:0] x0 = 8'd0;
    logic [6:0] y0 = 7'd0;
    logic [2:0] rd_color = 3'b000;
    logic [7:0] rd_x;
    logic [6:0] rd_y;
    logic       rd_en;
    logic       busy;
    logic       done;
    logic       hit;
    logic [8:0] hit_count;
    logic [7:0] first_hit_x;
    logic [6:0] first_hit_y;

    int    checks = 0;
    int    failures = 0;
    int    cyc = 0;
    addr_t aq[$];
    res_t  rq[$];
    res_t  last_res;
    logic [2:0] mem [0:119][0:159];

    region_reader #(.SIZE(16), .BG_COLOR(3'b000)) dut (
        .clock       (clock),
        .resetn      (resetn),
        .start       (start),
        .x0          (x0),
        .y0          (y0),
        .rd_x        (rd_x),
        .rd_y        (rd_y),
        .rd_en       (rd_en),
        .rd_color    (rd_color),
        .busy        (busy),
        .done        (done),
        .hit         (hit),
        .hit_count   (hit_count),
        .first_hit_x (first_hit_x),
        .first_hit_y (first_hit_y)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    // Framebuffer: returns junk when no valid read is issued, so a DUT that
    // samples off-screen or idle offsets would count spurious hits.
    always @(posedge clock)
        rd_color <= (rd_en && rd_x < 8'd160 && rd_y < 7'd120) ? mem[rd_y][rd_x] : 3'b111;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic fill(input int mode);
        for (int y = 0; y < 120; y++)
            for (int x = 0; x < 160; x++)
                case (mode)
                    0:       mem[y][x] = 3'b000;
                    1:       mem[y][x] = 3'b100;
                    default: mem[y][x] = ((x + 2 * y) % 7 == 0) ? 3'(1 + (x % 7)) : 3'b000;
                endcase
    endtask

    // Reference model: every offset in raster order with its expected
    // strobe/address, plus the final result for a scan accepted at cycle acc.
    task automatic push_scan(input int x, input int y, input int acc);
        res_t r;
        r = '{acc: acc, dcyc: acc + 257, hit: 1'b0, cnt: 9'd0, fx: 8'd0, fy: 7'd0};
        for (int dy = 0; dy < 16; dy++) begin
            for (int dx = 0; dx < 16; dx++) begin
                addr_t a;
                int    ux;
                int    uy;
                ux = x + dx;
                uy = y + dy;
                a.cyc = acc + dy * 16 + dx;
                a.en  = (ux < 160) && (uy < 120);
                a.x   = 8'(ux);
                a.y   = 7'(uy);
                aq.push_back(a);
                if (a.en && mem[uy][ux] != 3'b000) begin
                    r.cnt = r.cnt + 9'd1;
                    if (!r.hit) begin
                        r.hit = 1'b1;
                        r.fx  = 8'(ux);
                        r.fy  = 7'(uy);
                    end
                end
            end
        end
        rq.push_back(r);
        last_res = r;
    endtask

    // Launch a scan from IDLE; the accept edge is the next rising edge.
    task automatic go(input int x, input int y);
        @(posedge clock); #2;
        x0 = 8'(x);
        y0 = 7'(y);
        start = 1'b1;
        push_scan(x, y, cyc + 1);
        @(posedge clock); #2;
        start = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while ((aq.size() > 0 || rq.size() > 0) && n < 700) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_drained"}, 32'(aq.size() + rq.size()), 32'd0);
        @(posedge clock); #3;
        chk({tag, "_hold"}, 32'({hit, hit_count, first_hit_x, first_hit_y}),
            32'({last_res.hit, last_res.cnt, last_res.fx, last_res.fy}));
    endtask

    always @(negedge clock) begin
        logic  eb;
        addr_t a;
        res_t  r;
        eb = (rq.size() > 0) && (cyc >= rq[0].acc) && (cyc <= rq[0].acc + 256);
        chk("busy", 32'(busy), 32'(eb));
        if (aq.size() > 0 && aq[0].cyc == cyc) begin
            a = aq.pop_front();
            chk("rd_addr", 32'({rd_en, rd_x, rd_y}), 32'({a.en, a.x, a.y}));
        end else begin
            chk("rd_en_idle", 32'(rd_en), 32'd0);
        end
        if (rq.size() > 0 && rq[0].dcyc == cyc) begin
            r = rq.pop_front();
            chk("done", 32'(done), 32'd1);
            chk("hit", 32'(hit), 32'(r.hit));
            chk("hit_count", 32'(hit_count), 32'(r.cnt));
            chk("first_hit", 32'({first_hit_x, first_hit_y}), 32'({r.fx, r.fy}));
        end else begin
            chk("done_idle", 32'(done), 32'd0);
        end
    end

    initial begin
        fill(0);
        repeat (2) @(posedge clock);
        #3;
        chk("rst_ctl", 32'({rd_x, rd_y, rd_en, busy, done, hit}), 32'd0);
        chk("rst_res", 32'({hit_count, first_hit_x, first_hit_y}), 32'd0);
        resetn = 1'b1;

        // All background: 256 strobes, (10,20)..(25,35), no hits.
        go(10, 20);
        wait_idle("bg");

        // Single hit pixel.
        mem[35][15] = 3'b100;
        go(10, 20);
        wait_idle("single");

        // Region clipped by the right/bottom edge: 10x10 visible.
        fill(1);
        go(150, 110);
        wait_idle("clip");

        // Entirely off-screen with address wrap: no strobes, no hits.
        go(250, 125);
        wait_idle("wrap");

        // Restart attempt with new origin at cycle 50 must be ignored.
        fill(2);
        go(40, 60);
        repeat (49) @(posedge clock);
        #2;
        x0 = 8'd0;
        y0 = 7'd0;
        start = 1'b1;
        @(posedge clock); #2;
        start = 1'b0;
        wait_idle("restart");

        // Reset at cycle 100 of a scan: outputs clear, no done.
        go(5, 5);
        repeat (99) @(posedge clock);
        #2;
        resetn = 1'b0;
        #1;
        chk("midrst_ctl", 32'({rd_x, rd_y, rd_en, busy, done, hit}), 32'd0);
        chk("midrst_res", 32'({hit_count, first_hit_x, first_hit_y}), 32'd0);
        aq.delete();
        rq.delete();
        repeat (3) @(negedge clock);
        chk("midrst_hold", 32'({busy, rd_en, hit, hit_count}), 32'd0);
        @(posedge clock); #2;
        resetn = 1'b1;
        go(5, 5);
        wait_idle("after_rst");

        // start held high: back-to-back scans, one IDLE cycle between them.
        @(posedge clock); #2;
        x0 = 8'd70;
        y0 = 7'd30;
        start = 1'b1;
        push_scan(70, 30, cyc + 1);
        push_scan(70, 30, cyc + 1 + 259);
        repeat (270) @(posedge clock);
        #2;
        start = 1'b0;
        wait_idle("b2b");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
